// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT parameters and helpers.
// Contents:
//   K_DEF      default modulus exponent (q = 2^K+1)
//   q_of(k)    modulus 2^k+1
//   res_width  residue width in bits for exponent k (k+1)
package ntt_pkg;

    localparam int K_DEF = 16;

    function automatic longint unsigned q_of(input int k);
        return (64'd1 << k) + 64'd1;
    endfunction

    function automatic int res_width(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/modred_fermat_core.sv
// rtl/modred_fermat_core.sv - combinational Fermat-modulus fold and correction stages.
// Ports:
//   x_i    in   2K+2  unsigned operand
//   t_o    out  K+2   signed fold x0 + x2 - x1
//   t_i    in   K+2   registered fold value
//   neg_i  in   1     return (q - r) mod q instead of r
//   r_o    out  K+1   reduced (and optionally negated) residue, 0..q-1
module modred_fermat_core
    import ntt_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic [2*K+1:0]       x_i,
    output logic signed [K+1:0]  t_o,
    input  logic signed [K+1:0]  t_i,
    input  logic                 neg_i,
    output logic [K:0]           r_o
);

    localparam longint unsigned Q_L = q_of(K);
    localparam logic [K:0]       Q_K = Q_L[K:0];
    localparam logic signed [K+1:0] Q_S = $signed({1'b0, Q_K});

    // 2^K == -1 and 2^2K == +1 (mod q), so the three slices fold into one
    // small signed value; K+2 bits hold [-(2^K-1), 2^K+2] with wrap-free sign.
    function automatic logic signed [K+1:0] fold(input logic [2*K+1:0] x);
        logic [K+1:0] x0;
        logic [K+1:0] x1;
        logic [K+1:0] x2;
        x0 = {2'b00, x[K-1:0]};
        x1 = {2'b00, x[2*K-1:K]};
        x2 = {{K{1'b0}}, x[2*K+1:2*K]};
        return $signed(x0 + x2 - x1);
    endfunction

    // One add or subtract of q lands every fold value in [0, q-1]. Each true
    // result fits K+1 bits, so the arithmetic is done on the low K+1 bits only.
    function automatic logic [K:0] correct(input logic signed [K+1:0] t, input logic neg);
        logic [K:0] r;
        if (t[K+1]) begin
            r = t[K:0] + Q_K;
        end else if (t >= Q_S) begin
            r = t[K:0] - Q_K;
        end else begin
            r = t[K:0];
        end
        if (neg && (r != '0)) begin
            r = Q_K - r;
        end
        return r;
    endfunction

    assign t_o = fold(x_i);
    assign r_o = correct(t_i, neg_i);

endmodule

// File: rtl/modred_fermat_pipe.sv
// rtl/modred_fermat_pipe.sv - two-stage valid/ready pipelined reducer x mod (2^K+1).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake
//   in_data  [2K+2]              operand x
//   in_neg                       negate result (q - r) mod q
//   in_tag   [TAG_W]             sideband returned with the result
//   out_valid/out_ready          output handshake
//   out_data [K+1]               residue 0..q-1
//   out_tag  [TAG_W]             tag of the result
module modred_fermat_pipe
    import ntt_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*K+1:0]            in_data,
    input  logic                      in_neg,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [res_width(K)-1:0]   out_data,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int RW = res_width(K);

    logic                     v1_q,   v1_d;
    logic signed [K+1:0]      t1_q,   t1_d;
    logic                     neg1_q, neg1_d;
    logic [TAG_W-1:0]         tag1_q, tag1_d;
    logic                     v2_q,   v2_d;
    logic [RW-1:0]            r2_q,   r2_d;
    logic [TAG_W-1:0]         tag2_q, tag2_d;

    logic                     s1_load;
    logic                     s2_load;
    logic signed [K+1:0]      fold_t;
    logic [RW-1:0]            corr_r;

    modred_fermat_core #(.K(K)) u_core (
        .x_i   (in_data),
        .t_o   (fold_t),
        .t_i   (t1_q),
        .neg_i (neg1_q),
        .r_o   (corr_r)
    );

    // Readiness depends only on stage state and out_ready, never on in_valid.
    assign s2_load  = !v2_q || out_ready;
    assign s1_load  = !v1_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        v1_d   = v1_q;
        t1_d   = t1_q;
        neg1_d = neg1_q;
        tag1_d = tag1_q;
        v2_d   = v2_q;
        r2_d   = r2_q;
        tag2_d = tag2_q;

        if (s1_load) begin
            v1_d = in_valid;
            if (in_valid) begin
                t1_d   = fold_t;
                neg1_d = in_neg;
                tag1_d = in_tag;
            end
        end

        if (s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                r2_d   = corr_r;
                tag2_d = tag1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            t1_q   <= '0;
            neg1_q <= 1'b0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            r2_q   <= '0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            t1_q   <= t1_d;
            neg1_q <= neg1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            r2_q   <= r2_d;
            tag2_q <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = r2_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_modred_fermat_pipe.sv
// tb/tb_modred_fermat_pipe.sv - self-checking bench for modred_fermat_pipe (K=16 and K=8).
module tb_modred_fermat_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [33:0] in_data;
    logic        in_neg;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        in_ready16, out_valid16;
    logic [16:0] out_data16;
    logic [3:0]  out_tag16;
    logic        in_ready8, out_valid8;
    logic [8:0]  out_data8;
    logic [3:0]  out_tag8;

    int n_run  = 0;
    int n_fail = 0;
    int pops16 = 0;

    longint   sb16[$];
    longint   sb8[$];
    logic [3:0] tq16[$];
    logic [3:0] tq8[$];

    always #5 clk = ~clk;

    modred_fermat_pipe #(.K(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .in_neg(in_neg), .in_tag(in_tag),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_tag(out_tag16)
    );

    modred_fermat_pipe #(.K(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data[17:0]), .in_neg(in_neg), .in_tag(in_tag),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_tag(out_tag8)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_red(input longint x, input bit neg, input int k);
        longint q;
        longint r;
        q = (longint'(1) << k) + 1;
        r = x % q;
        return neg ? (q - r) % q : r;
    endfunction

    // Inputs were set at this falling edge; record what the next rising edge
    // transfers, compare delivered results, then advance one cycle.
    task automatic step();
        longint x;
        bit     exp_rdy;
        #1;
        exp_rdy = !(sb16.size() == 2 && !out_ready);
        check_eq("in_ready16", longint'(in_ready16), longint'(exp_rdy));
        check_eq("in_ready8", longint'(in_ready8), longint'(exp_rdy));
        if (out_valid16 && out_ready) begin
            pops16++;
            if (sb16.size() == 0) check_eq("unexpected16", 1, 0);
            else begin
                check_eq("data16", longint'(out_data16), sb16.pop_front());
                check_eq("tag16", longint'(out_tag16), longint'(tq16.pop_front()));
            end
        end
        if (out_valid8 && out_ready) begin
            if (sb8.size() == 0) check_eq("unexpected8", 1, 0);
            else begin
                check_eq("data8", longint'(out_data8), sb8.pop_front());
                check_eq("tag8", longint'(out_tag8), longint'(tq8.pop_front()));
            end
        end
        if (in_valid && in_ready16) begin
            x = longint'(in_data);
            sb16.push_back(ref_red(x, in_neg, 16));
            sb8.push_back(ref_red(x & 64'h3FFFF, in_neg, 8));
            tq16.push_back(in_tag);
            tq8.push_back(in_tag);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string nm, input longint x, input bit neg, input longint exp16);
        in_valid  = 1'b1;
        in_data   = x[33:0];
        in_neg    = neg;
        in_tag    = 4'hA;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq({nm, "_lat1_valid"}, longint'(out_valid16), 0);
        step();
        check_eq({nm, "_lat2_valid"}, longint'(out_valid16), 1);
        check_eq({nm, "_data"}, longint'(out_data16), exp16);
        check_eq({nm, "_tag"}, longint'(out_tag16), 10);
        step();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("drain16_empty", longint'(sb16.size()), 0);
        check_eq("drain8_empty", longint'(sb8.size()), 0);
    endtask

    longint dx[10] = '{65546, 65537, 65536, 64'h1_0000_0000, 64'hFFFF_FFFF,
                       64'h3_FFFF_FFFF, 0, 7, 65537, 1};
    bit     dn[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    longint de[10] = '{9, 0, 65536, 1, 0, 3, 0, 65530, 0, 65536};

    logic [33:0] rx;
    int          sent;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_neg    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid16", longint'(out_valid16), 0);
        check_eq("rst_out_data16", longint'(out_data16), 0);
        check_eq("rst_out_tag16", longint'(out_tag16), 0);
        check_eq("rst_out_valid8", longint'(out_valid8), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) directed($sformatf("dir%0d", i), dx[i], dn[i], de[i]);

        // Backpressure: tags 0..7 with out_ready pattern 1,0,0,1.
        sent   = 0;
        pops16 = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid = (sent < 8);
            in_tag   = sent[3:0];
            rx[31:0] = $urandom;
            rx[33:32] = 2'($urandom_range(0, 3));
            in_data  = rx;
            in_neg   = 1'($urandom_range(0, 1));
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (in_valid && in_ready16) sent++;
            step();
        end
        drain();
        check_eq("bp_sent", longint'(sent), 8);
        check_eq("bp_delivered", longint'(pops16), 8);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 34'd123456;
        in_neg    = 1'b0;
        step();
        in_data   = 34'd654321;
        step();
        in_valid  = 1'b0;
        check_eq("pre_rst_full", longint'(sb16.size()), 2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid16", longint'(out_valid16), 0);
        check_eq("mid_rst_valid8", longint'(out_valid8), 0);
        check_eq("mid_rst_data16", longint'(out_data16), 0);
        sb16.delete(); sb8.delete(); tq16.delete(); tq8.delete();
        out_ready = 1'b1;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("post_rst_valid", longint'(out_valid16), 0);
            step();
        end
        directed("post_rst", 65546, 1'b0, 9);

        // Random traffic with random backpressure, both moduli in lockstep.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rx[31:0]  = $urandom;
            rx[33:32] = 2'($urandom_range(0, 3));
            in_data   = rx;
            in_neg    = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
